// File: rtl/d_latch_sampler.sv
// Moves a word held in transparent latches into core_clk: sync lat_e, wait for close + SETTLE, capture lat_q.
// Latency SYNC_STAGES+1+SETTLE edges after lat_e falls; a capture into an unaccepted slot is dropped and flagged on overrun.
module d_latch_sampler #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lat_e,
  input  logic [WIDTH-1:0] lat_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(SETTLE) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPEN,
    S_SETTLE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   e_s;

  assign e_s  = sync_q[SYNC_STAGES-1];
  assign busy = (state != S_IDLE);

  // lat_q is deliberately not synchronized: it is only read after the latches have closed and settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lat_e};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (e_s) begin
            state <= S_OPEN;
          end
        end
        S_OPEN: begin
          if (!e_s) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
        end
        S_SETTLE: begin
          if (e_s) begin
            state <= S_OPEN;
          end else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            // an accept in this same cycle frees the slot, so refill wins over overrun
            if (out_valid && !out_ready) begin
              overrun <= 1'b1;
            end else begin
              out_data  <= lat_q;
              out_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_latch_sampler.sv
// Scenario bench for d_latch_sampler: expected words queued at stimulus, popped when the DUT presents them.
module tb_d_latch_sampler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lat_e;
  logic [7:0] lat_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  d_latch_sampler #(.WIDTH(8), .SYNC_STAGES(2), .SETTLE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lat_e     (lat_e),
    .lat_q     (lat_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] sb_pop();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  // On return lat_e has just been lowered; the next posedge is edge 1
  task automatic start_write(input logic [7:0] v, input int hi);
    lat_q = v;
    lat_e = 1'b1;
    tick(hi);
    lat_e = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lat_e = 1'b0; lat_q = 8'h00; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    exp_q.push_back(8'hA5);
    start_write(8'hA5, 3);
    tick(4);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_settle got %b exp 1", busy); end
    tick(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_edge5 got %b exp 1", out_valid); end
    exp = sb_pop();
    checks++; if (out_data !== exp) begin errors++; $display("FAIL basic_data got %h exp %h", out_data, exp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b exp 0", busy); end
  endtask

  task automatic test_accept();
    accept();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL accept_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL accept_data_hold got %h exp a5", out_data); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    exp_q.push_back(8'h11);
    start_write(8'h11, 3);
    tick(5);
    exp = sb_pop();
    checks++; if (out_data !== exp) begin errors++; $display("FAIL ovr_first_data got %h exp %h", out_data, exp); end
    start_write(8'h22, 3);
    tick(4);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
    tick(1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept got %h exp 11", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", out_valid); end
    tick(1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle got %b exp 0", overrun); end
    accept();
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    int rises = 0;
    logic prev;
    exp_q.push_back(8'h3C);
    start_write(8'h55, 3);
    tick(2);
    // lat_e back high before the settle window expires
    lat_e = 1'b1;
    lat_q = 8'h3C;
    prev = out_valid;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (out_valid && !prev) rises++;
      prev = out_valid;
    end
    lat_e = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (out_valid && !prev) rises++;
      prev = out_valid;
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL abort_capture_count got %0d exp 1", rises); end
    exp = sb_pop();
    checks++; if (out_data !== exp) begin errors++; $display("FAIL abort_data got %h exp %h", out_data, exp); end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    start_write(8'h01, 3);
    tick(5);
    exp = sb_pop();
    checks++; if (out_data !== exp) begin errors++; $display("FAIL refill_first got %h exp %h", out_data, exp); end
    start_write(8'h02, 3);
    tick(4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    exp = sb_pop();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL refill_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL refill_data got %h exp %h", out_data, exp); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL refill_overrun got %b exp 0", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int seen = 0;
    start_write(8'h77, 3);
    tick(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %b exp 0", overrun); end
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (out_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", seen); end
    exp_q.push_back(8'h5A);
    start_write(8'h5A, 2);
    tick(5);
    exp = sb_pop();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL rstmid_new_data got %h exp %h", out_data, exp); end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accept();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
